// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Imported by if_fetch_stage and its bench.
package if_fetch_stage_pkg;

   localparam int PC_W      = 32;
   localparam int INST_W    = 32;
   localparam int PC_INST_W = 64;

   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h1c00_0000;
   localparam logic [PC_W-1:0] PC_INC           = 32'd4;

   localparam int ADEF_BIT = 0;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding SRAM-like read,
// presents {pc, inst} and ADEF to ID, redirects on flush.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              IF_TO_ID_W = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  branch_flush_i,
   input  logic [PC_W-1:0]       branch_pc_i,
   input  logic                  excep_flush_i,
   input  logic [PC_W-1:0]       excep_pc_i,
   input  logic                  id_allowin_i,
   output logic                  if_to_id_valid_o,
   output logic [PC_INST_W-1:0]  pc_inst_obus,
   output logic [IF_TO_ID_W-1:0] to_id_obus,
   output logic                  inst_req_o,
   output logic [PC_W-1:0]       inst_addr_o,
   input  logic                  inst_addr_ok_i,
   input  logic                  inst_data_ok_i,
   input  logic [INST_W-1:0]     inst_rdata_i
);

   fetch_state_e      state;
   fetch_state_e      nxt_state;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   nxt_pc;
   logic [INST_W-1:0] inst;
   logic [INST_W-1:0] nxt_inst;
   logic              adef;
   logic              nxt_adef;
   logic              req_q;
   logic              valid_q;
   logic              flush;
   logic [PC_W-1:0]   target;
   logic              addr_hs;

   // Redirect source select: exception wins over branch.
   always_comb begin
      flush  = excep_flush_i | branch_flush_i;
      target = excep_flush_i ? excep_pc_i : branch_pc_i;
   end

   assign addr_hs = req_q & inst_addr_ok_i;

   // Next state / PC / payload; flush overrides every normal move.
   always_comb begin
      nxt_state = state;
      nxt_pc    = pc;
      nxt_inst  = inst;
      nxt_adef  = adef;
      if (flush) begin
         nxt_pc = target;
      end
      unique case (state)
         S_REQ: begin
            if (flush) begin
               nxt_state = addr_hs ? S_DROP : S_REQ;
            end else if (pc[1:0] != 2'b00) begin
               nxt_state = S_HOLD;
               nxt_inst  = '0;
               nxt_adef  = 1'b1;
            end else if (addr_hs) begin
               nxt_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush) begin
               nxt_state = inst_data_ok_i ? S_REQ : S_DROP;
            end else if (inst_data_ok_i) begin
               nxt_state = S_HOLD;
               nxt_inst  = inst_rdata_i;
               nxt_adef  = 1'b0;
            end
         end
         S_HOLD: begin
            if (flush) begin
               nxt_state = S_REQ;
            end else if (id_allowin_i) begin
               nxt_state = S_REQ;
               nxt_pc    = pc + PC_INC;
            end
         end
         S_DROP: begin
            if (inst_data_ok_i) begin
               nxt_state = S_REQ;
            end
         end
         default: nxt_state = S_REQ;
      endcase
   end

   // State, PC, payload and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_REQ;
         pc      <= RESET_PC;
         inst    <= '0;
         adef    <= 1'b0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= nxt_state;
         pc      <= nxt_pc;
         inst    <= nxt_inst;
         adef    <= nxt_adef;
         req_q   <= (nxt_state == S_REQ) && (nxt_pc[1:0] == 2'b00);
         valid_q <= (nxt_state == S_HOLD);
      end
   end

   // Flag bus: only ADEF is defined, the rest reads as zero.
   always_comb begin
      to_id_obus           = '0;
      to_id_obus[ADEF_BIT] = adef;
   end

   assign if_to_id_valid_o = valid_q;
   assign pc_inst_obus     = {pc, inst};
   assign inst_req_o       = req_q;
   assign inst_addr_o      = pc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with a handover
// scoreboard, then a randomized memory/flush phase.
module tb_if_fetch_stage;
   import if_fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        branch_flush_i = 1'b0;
   logic [31:0] branch_pc_i = '0;
   logic        excep_flush_i = 1'b0;
   logic [31:0] excep_pc_i = '0;
   logic        id_allowin_i = 1'b0;
   logic        if_to_id_valid_o;
   logic [63:0] pc_inst_obus;
   logic [0:0]  to_id_obus;
   logic        inst_req_o;
   logic [31:0] inst_addr_o;
   logic        inst_addr_ok_i = 1'b0;
   logic        inst_data_ok_i = 1'b0;
   logic [31:0] inst_rdata_i = '0;

   if_fetch_stage #(
      .RESET_PC   (32'h1c00_0000),
      .IF_TO_ID_W (1)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .branch_flush_i   (branch_flush_i),
      .branch_pc_i      (branch_pc_i),
      .excep_flush_i    (excep_flush_i),
      .excep_pc_i       (excep_pc_i),
      .id_allowin_i     (id_allowin_i),
      .if_to_id_valid_o (if_to_id_valid_o),
      .pc_inst_obus     (pc_inst_obus),
      .to_id_obus       (to_id_obus),
      .inst_req_o       (inst_req_o),
      .inst_addr_o      (inst_addr_o),
      .inst_addr_ok_i   (inst_addr_ok_i),
      .inst_data_ok_i   (inst_data_ok_i),
      .inst_rdata_i     (inst_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] pi;
      logic        adef;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_hand = 0;
   bit          rnd = 1'b0;
   logic [31:0] exp_pc = '0;
   logic        mis;
   bit          pend;
   int          acnt;
   int          dcnt;
   int          fl;
   logic [31:0] paddr;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'h1e80_0421;
   endfunction

   function automatic logic [31:0] rand_tgt(input logic [31:0] base);
      logic [31:0] t;
      t = base | ($urandom_range(0, 255) << 4);
      if ($urandom_range(0, 7) == 0) t = t | 32'h2;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every handover to ID against the scoreboard
   // (directed) or the reference PC sequence (random phase).
   always @(negedge clk) begin
      if (rst_n) begin
         if (if_to_id_valid_o)
            chk("no_stale_valid", {63'b0, pc_inst_obus[31:0] == 32'hdead_beef}, 64'd0);
         if (rnd) begin
            if (excep_flush_i || branch_flush_i) begin
               exp_pc = excep_flush_i ? excep_pc_i : branch_pc_i;
            end else if (if_to_id_valid_o && id_allowin_i) begin
               n_hand++;
               mis = (exp_pc[1:0] != 2'b00);
               chk("rand_pc_inst", pc_inst_obus,
                   {exp_pc, mis ? 32'h0 : memf(exp_pc)});
               chk("rand_adef", {63'b0, to_id_obus}, {63'b0, mis});
               exp_pc = exp_pc + 32'd4;
            end
         end else if (if_to_id_valid_o && id_allowin_i &&
                      !excep_flush_i && !branch_flush_i) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got handover %h expected none",
                        pc_inst_obus);
            end else begin
               e = sb.pop_front();
               chk("handover_pc_inst", pc_inst_obus, e.pi);
               chk("handover_adef", {63'b0, to_id_obus}, {63'b0, e.adef});
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_valid", {63'b0, if_to_id_valid_o}, 64'd0);
      chk("rst_req", {63'b0, inst_req_o}, 64'd0);
      chk("rst_addr", {32'b0, inst_addr_o}, {32'b0, 32'h1c00_0000});
      chk("rst_pc_inst", pc_inst_obus, {32'h1c00_0000, 32'h0});
      chk("rst_flags", {63'b0, to_id_obus}, 64'd0);

      // Basic fetch with one-cycle memory latency
      rst_n = 1'b1;
      step();
      chk("t1_req", {63'b0, inst_req_o}, 64'd1);
      chk("t1_addr", {32'b0, inst_addr_o}, {32'b0, 32'h1c00_0000});
      inst_addr_ok_i = 1'b1;
      step();
      inst_addr_ok_i = 1'b0;
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = 32'h0280_0421;
      sb.push_back('{{32'h1c00_0000, 32'h0280_0421}, 1'b0});
      id_allowin_i   = 1'b1;
      step();
      inst_data_ok_i = 1'b0;
      chk("t1_valid", {63'b0, if_to_id_valid_o}, 64'd1);
      step();
      id_allowin_i = 1'b0;
      chk("t1_next_addr", {32'b0, inst_addr_o}, {32'b0, 32'h1c00_0004});
      chk("t1_next_req", {63'b0, inst_req_o}, 64'd1);

      // ID stall in HOLD for five cycles
      inst_addr_ok_i = 1'b1;
      step();
      inst_addr_ok_i = 1'b0;
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = 32'h0011_2233;
      step();
      inst_data_ok_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_valid", {63'b0, if_to_id_valid_o}, 64'd1);
         chk("t2_bus", pc_inst_obus, {32'h1c00_0004, 32'h0011_2233});
         chk("t2_noreq", {63'b0, inst_req_o}, 64'd0);
         step();
      end
      sb.push_back('{{32'h1c00_0004, 32'h0011_2233}, 1'b0});
      id_allowin_i = 1'b1;
      step();
      id_allowin_i = 1'b0;
      chk("t2_addr", {32'b0, inst_addr_o}, {32'b0, 32'h1c00_0008});
      chk("t2_req", {63'b0, inst_req_o}, 64'd1);
      step();
      chk("t2_addr_once", {32'b0, inst_addr_o}, {32'b0, 32'h1c00_0008});

      // Branch flush in WAIT, stale data three cycles later
      inst_addr_ok_i = 1'b1;
      step();
      inst_addr_ok_i = 1'b0;
      branch_flush_i = 1'b1;
      branch_pc_i    = 32'h1c00_0100;
      step();
      branch_flush_i = 1'b0;
      chk("t3_drop_req", {63'b0, inst_req_o}, 64'd0);
      chk("t3_drop_valid", {63'b0, if_to_id_valid_o}, 64'd0);
      step();
      step();
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = 32'hdead_beef;
      step();
      inst_data_ok_i = 1'b0;
      chk("t3_addr", {32'b0, inst_addr_o}, {32'b0, 32'h1c00_0100});
      chk("t3_req", {63'b0, inst_req_o}, 64'd1);

      // Exception and branch together in HOLD with allowin
      inst_addr_ok_i = 1'b1;
      step();
      inst_addr_ok_i = 1'b0;
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = 32'h1234_5678;
      step();
      inst_data_ok_i = 1'b0;
      chk("t4_valid", {63'b0, if_to_id_valid_o}, 64'd1);
      chk("t4_bus", pc_inst_obus, {32'h1c00_0100, 32'h1234_5678});
      excep_flush_i  = 1'b1;
      excep_pc_i     = 32'h1c00_8000;
      branch_flush_i = 1'b1;
      branch_pc_i    = 32'h1c00_0100;
      id_allowin_i   = 1'b1;
      step();
      excep_flush_i  = 1'b0;
      branch_flush_i = 1'b0;
      id_allowin_i   = 1'b0;
      chk("t4_addr", {32'b0, inst_addr_o}, {32'b0, 32'h1c00_8000});
      chk("t4_req", {63'b0, inst_req_o}, 64'd1);

      // Misaligned branch target raises ADEF without a request
      branch_flush_i = 1'b1;
      branch_pc_i    = 32'h1c00_0102;
      step();
      branch_flush_i = 1'b0;
      chk("t5_noreq", {63'b0, inst_req_o}, 64'd0);
      sb.push_back('{{32'h1c00_0102, 32'h0}, 1'b1});
      id_allowin_i = 1'b1;
      step();
      chk("t5_valid", {63'b0, if_to_id_valid_o}, 64'd1);
      chk("t5_adef", {63'b0, to_id_obus}, 64'd1);
      step();
      id_allowin_i = 1'b0;
      chk("t5_noreq2", {63'b0, inst_req_o}, 64'd0);
      step();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      // Random memory latency and flushes
      rnd            = 1'b1;
      branch_flush_i = 1'b1;
      branch_pc_i    = 32'h1c00_1000;
      step();
      branch_flush_i = 1'b0;
      pend = 1'b0;
      acnt = -1;
      dcnt = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         inst_data_ok_i = 1'b0;
         inst_addr_ok_i = 1'b0;
         if (pend) begin
            if (dcnt == 0) begin
               inst_data_ok_i = 1'b1;
               inst_rdata_i   = memf(paddr);
               pend           = 1'b0;
            end else begin
               dcnt--;
            end
         end
         if (inst_req_o) begin
            chk("one_outstanding", {63'b0, pend}, 64'd0);
            if (!pend) begin
               if (acnt < 0) acnt = $urandom_range(0, 4);
               if (acnt == 0) begin
                  inst_addr_ok_i = 1'b1;
                  pend  = 1'b1;
                  paddr = inst_addr_o;
                  dcnt  = $urandom_range(0, 4);
                  acnt  = -1;
               end else begin
                  acnt--;
               end
            end
         end
         id_allowin_i   = ($urandom_range(0, 9) < 7);
         fl             = $urandom_range(0, 24);
         branch_flush_i = (fl == 0) || (fl == 2);
         excep_flush_i  = (fl == 1) || (fl == 2);
         branch_pc_i    = rand_tgt(32'h1c00_0000);
         excep_pc_i     = rand_tgt(32'h1c01_0000);
         step();
      end
      branch_flush_i = 1'b0;
      excep_flush_i  = 1'b0;
      id_allowin_i   = 1'b0;
      inst_addr_ok_i = 1'b0;
      inst_data_ok_i = 1'b0;
      chk("rand_progress", {63'b0, n_hand > 200}, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
